// File: rtl/cordic_phase_nco.sv
// Phase generator feeding the CORDIC sin/cos core: degrees in Q(EXPAND_BIT), wrapped to [0,360).
// Latency: first sample strobes div+1 clocks after the start-latch edge, then every div+1 clocks.
// Backpressure: none; start is refused (err) for out-of-range step/offset, stop aborts at once.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, stop           level-sampled run request / abort (stop wins)
//   step, offset          phase increment per sample and output offset, unsigned Q(EXPAND_BIT)
//   div                   sample period minus one, in clocks
//   burst_len             samples per burst, 0 = continuous
//   phase, phase_valid    registered phase and its one-cycle strobe
//   busy, done, err       running flag, burst-complete pulse, rejected-start pulse
module cordic_phase_nco #(
  parameter int DATA_WIDTH = 32,
  parameter int EXPAND_BIT = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  output logic [DATA_WIDTH-1:0] phase,
  output logic                  phase_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef logic [DATA_WIDTH:0] ext_t;

  localparam ext_t                 PHASE_MAX = ext_t'(360) << EXPAND_BIT;
  localparam logic [DIV_WIDTH-1:0] TICK_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] off_q, off_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DIV_WIDTH-1:0]  tick_q, tick_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] phase_q, phase_d;
  logic                  pv_q, pv_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Both operands are already below PHASE_MAX, so one conditional subtract wraps the sum.
  function automatic logic [DATA_WIDTH-1:0] wrap_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    ext_t s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= PHASE_MAX) s = s - PHASE_MAX;
    return s[DATA_WIDTH-1:0];
  endfunction

  logic                 in_range;
  logic                 sample_edge;
  logic                 last_sample;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign in_range    = ({1'b0, step} < PHASE_MAX) && ({1'b0, offset} < PHASE_MAX);
  assign sample_edge = (tick_q == div_q);
  assign cnt_inc     = cnt_q + CNT_ONE;
  // burst_len == 0 never terminates; the counter simply wraps.
  assign last_sample = (len_q != CNT_ZERO) && (cnt_inc == len_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (start && !stop && in_range) state_d = RUN;
    end else begin
      if (stop)                            state_d = IDLE;
      else if (sample_edge && last_sample) state_d = IDLE;
    end
  end

  // Output / datapath next values
  always_comb begin
    step_d  = step_q;
    off_d   = off_q;
    div_d   = div_q;
    len_d   = len_q;
    acc_d   = acc_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pv_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = (state_d == RUN);
    if (state_q == IDLE) begin
      if (start && !stop) begin
        if (in_range) begin
          step_d = step;
          off_d  = offset;
          div_d  = div;
          len_d  = burst_len;
          acc_d  = '0;
          tick_d = '0;
          cnt_d  = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (!stop) begin
      if (sample_edge) begin
        phase_d = wrap_add(acc_q, off_q);
        pv_d    = 1'b1;
        acc_d   = wrap_add(acc_q, step_q);
        tick_d  = '0;
        cnt_d   = cnt_inc;
        done_d  = last_sample;
      end else begin
        tick_d = tick_q + TICK_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= '0;
      off_q   <= '0;
      div_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      tick_q  <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      pv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      step_q  <= step_d;
      off_q   <= off_d;
      div_q   <= div_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pv_q    <= pv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = pv_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cordic_phase_nco.sv
module tb_cordic_phase_nco;

  localparam longint unsigned PM = 64'd360 * 64'd65536;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] step = '0;
  logic [31:0] offset = '0;
  logic [15:0] div = '0;
  logic [15:0] burst_len = '0;
  logic [31:0] phase;
  logic        phase_valid, busy, done, err;

  cordic_phase_nco dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .step(step), .offset(offset), .div(div), .burst_len(burst_len),
    .phase(phase), .phase_valid(phase_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a run is described by its latch edge and latched settings; the
  // k-th sample (1-based) lands k*(div+1) edges after the latch with phase
  // (offset + (k-1)*step) mod 360deg.
  bit              m_run = 0;
  longint unsigned m_step, m_off, m_div, m_len, m_t0;
  longint unsigned n_edge = 0;
  longint unsigned e_phase = 0;
  bit              e_pv = 0, e_done = 0, e_err = 0;

  logic [31:0] seen[$];
  int          err_cnt = 0;
  int          done_cnt = 0;

  task automatic model_edge();
    longint unsigned el, k;
    n_edge++;
    e_pv = 0; e_done = 0; e_err = 0;
    if (!m_run) begin
      if (start && !stop) begin
        if (longint'(step) < PM && longint'(offset) < PM) begin
          m_run = 1; m_step = step; m_off = offset; m_div = div; m_len = burst_len; m_t0 = n_edge;
        end else begin
          e_err = 1;
        end
      end
    end else if (stop) begin
      m_run = 0;
    end else begin
      el = n_edge - m_t0;
      if (el % (m_div + 1) == 0) begin
        k = el / (m_div + 1);
        e_phase = (m_off + (k - 1) * m_step) % PM;
        e_pv = 1;
        if (m_len != 0 && k == m_len) begin
          e_done = 1;
          m_run = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("phase", phase, e_phase);
    chk("phase_valid", phase_valid, e_pv);
    chk("busy", busy, m_run);
    chk("done", done, e_done);
    chk("err", err, e_err);
    if (phase_valid) seen.push_back(phase);
    if (err) err_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] o, input logic [15:0] d,
                    input logic [15:0] l);
    step = s; offset = o; div = d; burst_len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_seen(input string tag, input logic [31:0] exp[$]);
    chk({tag, "_count"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++) chk(tag, seen[i], exp[i]);
  endtask

  initial begin
    logic [31:0] hold_ph;
    int          e0, d0;

    #2;
    chk("rst_phase", phase, 0);
    chk("rst_pv", phase_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    #10 rst_n = 1'b1;

    // Burst with exact wrap at 360
    seen.delete();
    go(32'd7864320, 32'd0, 16'd0, 16'd4);
    repeat (5) tick();
    chk_seen("burst_wrap", '{32'd0, 32'd7864320, 32'd15728640, 32'd0});
    chk("burst_busy_after", busy, 0);

    // Offset plus divider; immediate restart after a done exercises restart from acc=0
    seen.delete();
    go(32'd1966080, 32'd22937600, 16'd3, 16'd3);
    repeat (13) tick();
    chk_seen("off_div", '{32'd22937600, 32'd1310720, 32'd3276800});

    // Rejected start, then an accepted one
    seen.delete();
    e0 = err_cnt;
    go(32'd23592960, 32'd0, 16'd0, 16'd2);
    repeat (2) tick();
    chk("rej_err_pulses", err_cnt - e0, 1);
    chk("rej_no_strobe", seen.size(), 0);
    go(32'd0, 32'd23592960, 16'd0, 16'd2);
    tick();
    chk("rej_off_err_pulses", err_cnt - e0, 2);
    go(32'd65536, 32'd0, 16'd0, 16'd2);
    repeat (3) tick();
    chk_seen("after_rej", '{32'd0, 32'd65536});

    // Stop on a sample edge in continuous mode
    d0 = done_cnt;
    go(32'd655360, 32'd100, 16'd1, 16'd0);
    repeat (3) tick();
    hold_ph = phase;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_no_strobe", phase_valid, 0);
    chk("stop_phase_hold", phase, hold_ph);
    repeat (3) tick();
    chk("stop_idle", busy, 0);
    chk("stop_phase_kept", phase, hold_ph);
    chk("stop_no_done", done_cnt - d0, 0);

    // Reset mid-run clears outputs at once; next start resumes from offset
    go(32'd3000000, 32'd5000, 16'd0, 16'd0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_phase", phase, 0);
    chk("mrst_pv", phase_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    m_run = 0; e_phase = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen.delete();
    go(32'd3000000, 32'd5000, 16'd1, 16'd2);
    repeat (4) tick();
    chk_seen("mrst_resume", '{32'd5000, 32'd3005000});

    // Start+stop together in IDLE, then a start pulse during RUN
    start = 1'b1; stop = 1'b1; step = 32'd1; offset = 32'd0;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_idle", busy, 0);
    seen.delete();
    go(32'd1000, 32'd7, 16'd1, 16'd3);
    tick();
    start = 1'b1; step = 32'd99; offset = 32'd1; div = 16'd0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk_seen("start_in_run", '{32'd7, 32'd1007, 32'd2007});

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      step  = ($urandom_range(0, 15) == 0) ? 32'(PM) + $urandom_range(0, 1000)
                                           : $urandom_range(0, 32'(PM) - 1);
      offset = ($urandom_range(0, 15) == 0) ? 32'(PM) + $urandom_range(0, 1000)
                                            : $urandom_range(0, 32'(PM) - 1);
      div       = 16'($urandom_range(0, 5));
      burst_len = 16'($urandom_range(0, 6));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
